// File: rtl/dmem_unit_if.sv
// Request/response bundle between the MA stage and the data-memory unit.
// master = pipeline side (drives requests), slave = memory unit.
// Signals: req_valid/req_ready handshake, req_we/addr/funct3/wdata payload,
// resp_valid one-cycle pulse with resp_rdata/resp_err.
interface dmem_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_unit.sv
// Purpose: word-organised data RAM for the MA stage with RV32I sub-word loads/stores and error reporting.
// Latency: response pulse LATENCY cycles after acceptance (first visible after edge accept+LATENCY-1).
// Backpressure: req_ready low while an access is in flight; one request outstanding at a time.
// Ports: clk, rst_n (async active-low), bus (dmem_unit_if.slave: request handshake + response pulse).
module dmem_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_unit_if.slave   bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [2:0]       cnt;

  // Captured request, used when the response edge comes after the accept edge.
  logic             cap_we;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_lane;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_err;

  logic [31:0]      mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- decode
  logic             accept;
  logic [31:0]      off;
  logic [31:0]      word_off;
  logic             in_range;
  logic             misalign;
  logic             illegal;
  logic             in_err;
  logic [IDX_W-1:0] in_idx;
  logic [3:0]       be;
  logic [31:0]      wd;

  assign bus.req_ready = (state == IDLE) & rst_n;
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    off      = bus.req_addr - BASE_ADDR;
    word_off = off >> 2;
    // addr below base wraps to a huge offset, but the explicit compare keeps intent clear.
    in_range = (bus.req_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
    misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    illegal  = (bus.req_funct3[1:0] == 2'b11) || (bus.req_we && bus.req_funct3[2]);
    in_err   = !in_range || misalign || illegal;
    in_idx   = word_off[IDX_W-1:0];

    be = 4'b0000;
    wd = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        be = 4'b0001 << bus.req_addr[1:0];
        wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------- storage
  // Stores commit at the accept edge; rejected requests never touch the array.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !in_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[in_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- response
  // With LATENCY==1 the response edge is the accept edge, so take the live request.
  logic             rsp_we;
  logic [2:0]       rsp_f3;
  logic [1:0]       rsp_lane;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_err;
  logic             emit;
  logic [31:0]      rd_word;

  always_comb begin
    if (LATENCY == 1) begin
      rsp_we   = bus.req_we;
      rsp_f3   = bus.req_funct3;
      rsp_lane = bus.req_addr[1:0];
      rsp_idx  = in_idx;
      rsp_err  = in_err;
      emit     = accept;
    end else begin
      rsp_we   = cap_we;
      rsp_f3   = cap_f3;
      rsp_lane = cap_lane;
      rsp_idx  = cap_idx;
      rsp_err  = cap_err;
      emit     = (state == BUSY) && (cnt == 3'd0);
    end
    rd_word = mem[rsp_idx];
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   fmt_load = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   fmt_load = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      cap_we         <= 1'b0;
      cap_f3         <= 3'd0;
      cap_lane       <= 2'd0;
      cap_idx        <= '0;
      cap_err        <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= emit;
      if (emit) begin
        bus.resp_err   <= rsp_err;
        bus.resp_rdata <= (rsp_err || rsp_we) ? 32'd0 : fmt_load(rd_word, rsp_f3, rsp_lane);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            cap_we   <= bus.req_we;
            cap_f3   <= bus.req_funct3;
            cap_lane <= bus.req_addr[1:0];
            cap_idx  <= in_idx;
            cap_err  <= in_err;
            if (LATENCY > 1) begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt != 3'd0) cnt   <= cnt - 3'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: three instances (LATENCY 1, 3, 4) share clock/reset and
// request fields; `sel` chooses which one sees req_valid. Expected responses are
// queued at issue time and checked (data, error, arrival cycle) when they appear.
module tb_dmem_unit;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  int          sel = 0;

  dmem_unit_if if1 ();
  dmem_unit_if if3 ();
  dmem_unit_if if4 ();

  assign if1.req_valid = req_valid & (sel == 0);
  assign if3.req_valid = req_valid & (sel == 1);
  assign if4.req_valid = req_valid & (sel == 2);
  assign if1.req_we = req_we;  assign if1.req_addr = req_addr;
  assign if1.req_funct3 = req_funct3;  assign if1.req_wdata = req_wdata;
  assign if3.req_we = req_we;  assign if3.req_addr = req_addr;
  assign if3.req_funct3 = req_funct3;  assign if3.req_wdata = req_wdata;
  assign if4.req_we = req_we;  assign if4.req_addr = req_addr;
  assign if4.req_funct3 = req_funct3;  assign if4.req_wdata = req_wdata;

  dmem_unit #(.LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_unit #(.LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  dmem_unit #(.LATENCY(4)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  logic        s_ready, s_rv, s_err;
  logic [31:0] s_rdata;
  int          s_lat;
  always_comb begin
    s_ready = if1.req_ready; s_rv = if1.resp_valid; s_err = if1.resp_err;
    s_rdata = if1.resp_rdata; s_lat = 1;
    if (sel == 1) begin
      s_ready = if3.req_ready; s_rv = if3.resp_valid; s_err = if3.resp_err;
      s_rdata = if3.resp_rdata; s_lat = 3;
    end else if (sel == 2) begin
      s_ready = if4.req_ready; s_rv = if4.resp_valid; s_err = if4.resp_err;
      s_rdata = if4.resp_rdata; s_lat = 4;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Scoreboard consumer: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_rv) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (s_rdata !== e.rdata) begin
          fails++; $display("FAIL %s rdata: got %h required %h", e.name, s_rdata, e.rdata);
        end
        checks++;
        if (s_err !== e.err) begin
          fails++; $display("FAIL %s err: got %b required %b", e.name, s_err, e.err);
        end
        checks++;
        if (cyc !== e.due) begin
          fails++; $display("FAIL %s timing: got cycle %0d required %0d", e.name, cyc, e.due);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input int s, input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   g;
    g = 0;
    sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    #1;
    while (!s_ready && g < 50) begin
      @(negedge clk); g++;
    end
    if (!s_ready) begin
      checks++; fails++;
      $display("FAIL %s accept_timeout: got req_ready=0 for 50 cycles, required 1", nm);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rd; e.err = exp_err; e.due = cyc + s_lat; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk); g++;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s drain: got %0d responses outstanding, required 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({if1.req_ready, if3.req_ready, if4.req_ready} !== 3'b000) begin
      fails++; $display("FAIL reset_ready: got %b required 000",
                        {if1.req_ready, if3.req_ready, if4.req_ready});
    end
    checks++;
    if ({if1.resp_valid, if3.resp_valid, if4.resp_valid, if1.resp_err} !== 4'b0000 ||
        if1.resp_rdata !== 32'd0) begin
      fails++; $display("FAIL reset_resp: got valid/err %b rdata %h required 0",
                        {if1.resp_valid, if3.resp_valid, if4.resp_valid, if1.resp_err},
                        if1.resp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({if1.req_ready, if3.req_ready, if4.req_ready} !== 3'b111) begin
      fails++; $display("FAIL release_ready: got %b required 111",
                        {if1.req_ready, if3.req_ready, if4.req_ready});
    end
    // Mid-cycle pulse: ready must drop immediately, without waiting for a clock.
    @(posedge clk); #2 rst_n = 1'b0; #1;
    checks++;
    if ({if1.req_ready, if1.resp_valid} !== 2'b00) begin
      fails++; $display("FAIL pulse_reset: got ready/valid %b required 00",
                        {if1.req_ready, if1.resp_valid});
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if1.req_ready !== 1'b1) begin
      fails++; $display("FAIL pulse_release_ready: got %b required 1", if1.req_ready);
    end
  endtask

  task automatic test_subword();
    issue(0, "sw0",   1'b1, 3'b010, 32'h10010000, 32'h80FF7F01, 32'h0, 1'b0);
    issue(0, "lb1",   1'b0, 3'b000, 32'h10010001, 32'h0, 32'h0000007F, 1'b0);
    issue(0, "lbu1",  1'b0, 3'b100, 32'h10010001, 32'h0, 32'h0000007F, 1'b0);
    issue(0, "lb3",   1'b0, 3'b000, 32'h10010003, 32'h0, 32'hFFFFFF80, 1'b0);
    issue(0, "lbu3",  1'b0, 3'b100, 32'h10010003, 32'h0, 32'h00000080, 1'b0);
    issue(0, "lh2",   1'b0, 3'b001, 32'h10010002, 32'h0, 32'hFFFF80FF, 1'b0);
    issue(0, "lhu2",  1'b0, 3'b101, 32'h10010002, 32'h0, 32'h000080FF, 1'b0);
    issue(0, "lh0",   1'b0, 3'b001, 32'h10010000, 32'h0, 32'h00007F01, 1'b0);
    issue(0, "lw0",   1'b0, 3'b010, 32'h10010000, 32'h0, 32'h80FF7F01, 1'b0);
    drain("subword");
  endtask

  task automatic test_byte_lanes();
    issue(0, "sw4",   1'b1, 3'b010, 32'h10010004, 32'h00000000, 32'h0, 1'b0);
    issue(0, "sb6",   1'b1, 3'b000, 32'h10010006, 32'hDEADBEAA, 32'h0, 1'b0);
    issue(0, "sh4",   1'b1, 3'b001, 32'h10010004, 32'hCAFE1234, 32'h0, 1'b0);
    issue(0, "lw4",   1'b0, 3'b010, 32'h10010004, 32'h0, 32'h00AA1234, 1'b0);
    issue(0, "sh6",   1'b1, 3'b001, 32'h10010006, 32'h0000BEEF, 32'h0, 1'b0);
    issue(0, "lw4b",  1'b0, 3'b010, 32'h10010004, 32'h0, 32'hBEEF1234, 1'b0);
    drain("byte_lanes");
  endtask

  task automatic test_errors();
    issue(0, "lw_mis",   1'b0, 3'b010, 32'h10010002, 32'h0, 32'h0, 1'b1);
    issue(0, "lh_mis",   1'b0, 3'b001, 32'h10010001, 32'h0, 32'h0, 1'b1);
    issue(0, "sw_last",  1'b1, 3'b010, 32'h10010000 + 4*(DEPTH-1), 32'h5555AAAA, 32'h0, 1'b0);
    issue(0, "sw_oor",   1'b1, 3'b010, 32'h10010000 + 4*DEPTH, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(0, "lw_last",  1'b0, 3'b010, 32'h10010000 + 4*(DEPTH-1), 32'h0, 32'h5555AAAA, 1'b0);
    issue(0, "f3_011",   1'b0, 3'b011, 32'h10010000, 32'h0, 32'h0, 1'b1);
    issue(0, "below",    1'b0, 3'b010, 32'h0FFFFFFC, 32'h0, 32'h0, 1'b1);
    issue(0, "top",      1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
    issue(0, "sb_uns",   1'b1, 3'b100, 32'h10010004, 32'h00000077, 32'h0, 1'b1);
    issue(0, "sh_mis",   1'b1, 3'b001, 32'h10010005, 32'h00007777, 32'h0, 1'b1);
    issue(0, "lw4_kept", 1'b0, 3'b010, 32'h10010004, 32'h0, 32'hBEEF1234, 1'b0);
    drain("errors");
  endtask

  task automatic test_latency3();
    issue(1, "l3_sw", 1'b1, 3'b010, 32'h10010010, 32'hA5A50F0F, 32'h0, 1'b0);
    checks++;
    if (s_ready !== 1'b0) begin
      fails++; $display("FAIL l3_busy1 ready: got %b required 0", s_ready);
    end
    @(negedge clk);
    checks++;
    if ({s_ready, s_rv} !== 2'b00) begin
      fails++; $display("FAIL l3_busy2 ready/valid: got %b required 00", {s_ready, s_rv});
    end
    @(negedge clk);
    checks++;
    if ({s_ready, s_rv} !== 2'b11) begin
      fails++; $display("FAIL l3_resp ready/valid: got %b required 11", {s_ready, s_rv});
    end
    issue(1, "l3_lw",  1'b0, 3'b010, 32'h10010010, 32'h0, 32'hA5A50F0F, 1'b0);
    issue(1, "l3_lbu", 1'b0, 3'b100, 32'h10010011, 32'h0, 32'h0000000F, 1'b0);
    issue(1, "l3_lh",  1'b0, 3'b001, 32'h10010012, 32'h0, 32'hFFFFA5A5, 1'b0);
    drain("latency3");
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(2, "l4_sw", 1'b1, 3'b010, 32'h10010020, 32'h13579BDF, 32'h0, 1'b0);
    drain("l4_store");
    issue(2, "l4_dropped", 1'b0, 3'b010, 32'h10010020, 32'h0, 32'h13579BDF, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({s_ready, s_rv} !== 2'b00) begin
      fails++; $display("FAIL mid_reset ready/valid: got %b required 00", {s_ready, s_rv});
    end
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_rv) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++; $display("FAIL dropped_resp: got %0d responses required 0", seen);
    end
    issue(2, "l4_lw_after", 1'b0, 3'b010, 32'h10010020, 32'h0, 32'h13579BDF, 1'b0);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_subword();
    test_byte_lanes();
    test_errors();
    test_latency3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
